// File: rtl/maxnet_controller_pkg.sv
// maxnet_controller_pkg: shared state encoding for the MaxNet sequencing controller
package maxnet_controller_pkg;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        CHECK  = 3'd2,
        UPDATE = 3'd3,
        DONE   = 3'd4
    } state_t;
endpackage

// File: rtl/maxnet_onehot_enc.sv
// maxnet_onehot_enc: combinational index encoder with one-hot and all-zero detection
//   active    in  N      per-neuron nonzero flags
//   idx       out IDX_W  index of the highest set bit (meaningful when is_onehot)
//   is_onehot out 1      exactly one bit of active set
//   is_zero   out 1      no bit of active set
module maxnet_onehot_enc
    import maxnet_controller_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     active,
    output logic [IDX_W-1:0] idx,
    output logic             is_onehot,
    output logic             is_zero
);
    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++)
            if (active[i]) idx = IDX_W'(i);
    end
    assign is_zero   = active == '0;
    assign is_onehot = !is_zero && (active & (active - N'(1))) == '0;
endmodule

// File: rtl/maxnet_controller.sv
// maxnet_controller: load / iterate / stop sequencer for a MaxNet winner-take-all datapath
//   clk, rst_n    clock and synchronous active-low reset
//   start         begin a run (accepted only in IDLE or DONE)
//   active        per-neuron nonzero flags from the datapath
//   init_ld       one-cycle load strobe for the neuron registers
//   iter_en       one-cycle inhibition update strobe
//   busy / done   run in progress / run finished (done held until restart)
//   winner_valid, winner, timeout, iter_count   results of the current or last run
module maxnet_controller
    import maxnet_controller_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_ITER = 16,
    parameter int ITER_W   = 5,
    parameter int IDX_W    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [N-1:0]      active,
    output logic              init_ld,
    output logic              iter_en,
    output logic              busy,
    output logic              done,
    output logic              winner_valid,
    output logic [IDX_W-1:0]  winner,
    output logic              timeout,
    output logic [ITER_W-1:0] iter_count
);
    state_t           state;
    logic [IDX_W-1:0] enc_idx;
    logic             is_onehot;
    logic             is_zero;
    logic             accept;

    maxnet_onehot_enc #(.N(N), .IDX_W(IDX_W)) u_enc (
        .active(active),
        .idx(enc_idx),
        .is_onehot(is_onehot),
        .is_zero(is_zero)
    );

    assign accept = start && (state == IDLE || state == DONE);

    // Outputs are registered alongside the state so each strobe is high
    // exactly for the cycle its state is occupied; results are cleared on
    // entry to LOAD so stale values never show during a new run.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            init_ld      <= 1'b0;
            iter_en      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            winner_valid <= 1'b0;
            winner       <= '0;
            timeout      <= 1'b0;
            iter_count   <= '0;
        end else if (accept) begin
            state        <= LOAD;
            init_ld      <= 1'b1;
            busy         <= 1'b1;
            done         <= 1'b0;
            winner_valid <= 1'b0;
            winner       <= '0;
            timeout      <= 1'b0;
            iter_count   <= '0;
        end else begin
            case (state)
                LOAD: begin
                    state   <= CHECK;
                    init_ld <= 1'b0;
                end
                CHECK: begin
                    if (is_onehot) begin
                        state        <= DONE;
                        busy         <= 1'b0;
                        done         <= 1'b1;
                        winner       <= enc_idx;
                        winner_valid <= 1'b1;
                    end else if (is_zero) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (iter_count == ITER_W'(MAX_ITER)) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                    end else begin
                        state   <= UPDATE;
                        iter_en <= 1'b1;
                    end
                end
                UPDATE: begin
                    state      <= CHECK;
                    iter_en    <= 1'b0;
                    iter_count <= iter_count + ITER_W'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_maxnet_controller.sv
// tb_maxnet_controller: directed bench with a cycle-level outcome model for maxnet_controller
module tb_maxnet_controller;
    localparam int N = 4, MAX_ITER = 3, ITER_W = 5, IDX_W = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [N-1:0]      active = '0;
    logic              init_ld, iter_en, busy, done, winner_valid, timeout;
    logic [IDX_W-1:0]  winner;
    logic [ITER_W-1:0] iter_count;
    int                checks = 0;
    int                failures = 0;

    always #5 clk = ~clk;

    maxnet_controller #(.N(N), .MAX_ITER(MAX_ITER), .ITER_W(ITER_W), .IDX_W(IDX_W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .active(active),
        .init_ld(init_ld),
        .iter_en(iter_en),
        .busy(busy),
        .done(done),
        .winner_valid(winner_valid),
        .winner(winner),
        .timeout(timeout),
        .iter_count(iter_count)
    );

    task automatic chk(input string nm, input logic [7:0] a, input logic [7:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, a, e);
        end
    endtask

    // Sequence of active vectors the datapath presents: entry j after j updates,
    // the last entry repeating once the list runs out.
    logic [N-1:0] seq [8];
    int           len = 1;

    task automatic load(input logic [N-1:0] a0, a1, a2, a3, input int n);
        seq[0] = a0; seq[1] = a1; seq[2] = a2; seq[3] = a3;
        len = n;
    endtask

    typedef struct packed {
        int         k;
        logic       wv;
        logic [1:0] w;
        logic       to;
    } res_t;

    // Outcome of a run: number of updates k and the final result flags.
    function automatic res_t predict();
        res_t r;
        logic [N-1:0] a;
        r = '0;
        for (int j = 0; j <= MAX_ITER; j++) begin
            a = seq[j < len ? j : len - 1];
            r.k = j;
            if ($countones(a) == 1) begin
                r.wv = 1'b1;
                for (int b = 0; b < N; b++) if (a[b]) r.w = 2'(b);
                return r;
            end
            if (a == '0) return r;
            if (j == MAX_ITER) begin
                r.to = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    // Model: t = cycles since the accepted start edge; everything follows from t and k.
    bit   m_on = 1'b0;
    bit   m_seen = 1'b0;
    int   t = 0;
    res_t m_r = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_on   <= 1'b0;
            t      <= 0;
            m_seen <= 1'b1;
        end else if (start && (!m_on || t >= 3 + 2 * m_r.k)) begin
            m_on <= 1'b1;
            t    <= 1;
            m_r  <= predict();
        end else if (m_on) begin
            t <= t + 1;
        end
    end

    // Datapath stand-in: reloads on init_ld, steps through seq on iter_en.
    int p = 0, n_ld = 0, n_en = 0;
    always @(negedge clk) begin
        if (init_ld) begin
            p      <= 0;
            active <= seq[0];
            n_ld   <= n_ld + 1;
        end else if (iter_en) begin
            p      <= p + 1;
            active <= seq[p + 1 < len ? p + 1 : len - 1];
            n_en   <= n_en + 1;
        end
    end

    always @(negedge clk) begin
        int fin, ic;
        bit fd;
        if (m_seen) begin
            fin = 3 + 2 * m_r.k;
            fd  = m_on && t >= fin;
            ic  = !m_on || t <= 3 ? 0 : ((t - 2) / 2 < m_r.k ? (t - 2) / 2 : m_r.k);
            chk("m_init_ld", init_ld, m_on && t == 1);
            chk("m_iter_en", iter_en, m_on && t >= 3 && t <= 2 * m_r.k + 1 && t % 2 == 1);
            chk("m_busy", busy, m_on && t >= 1 && t < fin);
            chk("m_done", done, fd);
            chk("m_winner_valid", winner_valid, fd && m_r.wv);
            chk("m_winner", winner, fd ? m_r.w : 2'd0);
            chk("m_timeout", timeout, fd && m_r.to);
            chk("m_iter_count", iter_count, ic);
        end
    end

    task automatic run(input string nm, input int lat, input int w, input int wv, input int to, input int ic);
        int c, e0;
        e0 = n_en;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk({nm, "_init_ld"}, init_ld, 1);
        chk({nm, "_cleared"}, {done, winner_valid, timeout}, 0);
        c = 1;
        while (!done && c < 60) begin
            @(negedge clk);
            c++;
        end
        chk({nm, "_latency"}, c, lat);
        chk({nm, "_winner"}, winner, w);
        chk({nm, "_winner_valid"}, winner_valid, wv);
        chk({nm, "_timeout"}, timeout, to);
        chk({nm, "_iter_count"}, iter_count, ic);
        chk({nm, "_iter_en_pulses"}, n_en - e0, ic);
    endtask

    initial begin
        int c, l0;
        load(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1);
        repeat (2) @(negedge clk);
        chk("rst_outputs", {init_ld, iter_en, busy, done, winner_valid, timeout}, 0);
        chk("rst_iter_count", iter_count, 0);
        rst_n = 1'b1;
        @(negedge clk);

        load(4'b0111, 4'b0101, 4'b0100, 4'b0100, 3);
        run("t1", 7, 2, 1, 0, 2);
        load(4'b1000, 4'b1000, 4'b1000, 4'b1000, 1);
        run("t2", 3, 3, 1, 0, 0);
        load(4'b0011, 4'b0000, 4'b0000, 4'b0000, 2);
        run("t3", 5, 0, 0, 0, 1);
        load(4'b0011, 4'b0011, 4'b0011, 4'b0011, 1);
        run("t4", 9, 0, 0, 1, 3);
        load(4'b0010, 4'b0010, 4'b0010, 4'b0010, 1);
        run("t6", 3, 1, 1, 0, 0);
        load(4'b0011, 4'b0011, 4'b0011, 4'b0001, 4);
        run("hot_at_max", 9, 0, 1, 0, 3);

        load(4'b0100, 4'b0100, 4'b0100, 4'b0100, 1);
        @(negedge clk) start = 1'b1;
        c = 0;
        while (!done && c < 60) begin
            @(negedge clk);
            c++;
        end
        chk("hold_first_done", done, 1);
        @(negedge clk) start = 1'b0;
        chk("hold_restart_init_ld", init_ld, 1);
        chk("hold_restart_done", done, 0);
        c = 0;
        while (!done && c < 60) begin
            @(negedge clk);
            c++;
        end
        chk("hold_winner", winner, 2);

        load(4'b0011, 4'b0011, 4'b0011, 4'b0011, 1);
        l0 = n_ld;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        c = 0;
        while (!iter_en && c < 20) begin
            @(negedge clk);
            c++;
        end
        chk("t5_in_update", iter_en, 1);
        rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        chk("t5_rst_outputs", {init_ld, iter_en, busy, done, winner_valid, timeout}, 0);
        chk("t5_rst_iter_count", iter_count, 0);
        chk("t5_rst_winner", winner, 0);
        chk("t5_single_init_ld", n_ld - l0, 1);
        repeat (3) @(negedge clk);
        chk("t5_idle_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
